// File: rtl/sync_updown_counter_mod_nbit_if.sv
// Control and status bundle for the n-bit up/down counter.
// master drives controls; slave is the counter itself.
interface sync_updown_counter_mod_nbit_if #(
  parameter int n = 7
);
  logic         clear;
  logic         load;
  logic [n-1:0] D;
  logic         en;
  logic         up_down;
  logic [n-1:0] max_val;
  logic [n-1:0] Q;
  logic         tc;
  logic         ovf;

  modport master (
    output clear, load, D, en, up_down, max_val,
    input  Q, tc, ovf
  );

  modport slave (
    input  clear, load, D, en, up_down, max_val,
    output Q, tc, ovf
  );
endinterface

// File: rtl/sync_updown_counter_mod_nbit.sv
// Synchronous n-bit up/down counter with runtime modulus,
// load, clear, wrap/saturate and chainable terminal count.
module sync_updown_counter_mod_nbit #(
  parameter int n        = 7,
  parameter bit SATURATE = 1'b0
) (
  input logic                           clk,
  input logic                           reset,
  sync_updown_counter_mod_nbit_if.slave bus
);

  logic [n-1:0] q_r;
  logic [n-1:0] q_nxt;
  logic         ovf_r;
  logic         ovf_nxt;
  logic         at_top;
  logic         at_zero;
  logic         hit;

  // Boundary detect; >= so a loaded value above max_val wraps up.
  always_comb begin
    at_top  = (q_r >= bus.max_val);
    at_zero = (q_r == '0);
    hit     = bus.up_down ? at_top : at_zero;
  end

  // Next count and sticky flag, priority clear > load > en.
  always_comb begin
    q_nxt   = q_r;
    ovf_nxt = ovf_r;
    if (bus.clear) begin
      q_nxt   = '0;
      ovf_nxt = 1'b0;
    end else if (bus.load) begin
      q_nxt = bus.D;
    end else if (bus.en) begin
      if (hit) ovf_nxt = 1'b1;
      if (bus.up_down) begin
        if (at_top) q_nxt = SATURATE ? q_r : '0;
        else        q_nxt = q_r + 1'b1;
      end else begin
        if (at_zero) q_nxt = SATURATE ? '0 : bus.max_val;
        else         q_nxt = q_r - 1'b1;
      end
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r   <= '0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt;
      ovf_r <= ovf_nxt;
    end
  end

  assign bus.Q   = q_r;
  assign bus.ovf = ovf_r;
  assign bus.tc  = bus.en & hit;

endmodule

// File: tb/tb_sync_updown_counter_mod_nbit.sv
// Directed bench: vector table plus hand sequences for reset,
// saturate mode and a two-stage cascade.
module tb_sync_updown_counter_mod_nbit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_updown_counter_mod_nbit_if #(.n(4)) ifw ();
  sync_updown_counter_mod_nbit_if #(.n(4)) ifs ();
  sync_updown_counter_mod_nbit_if #(.n(4)) iflo ();
  sync_updown_counter_mod_nbit_if #(.n(4)) ifhi ();

  sync_updown_counter_mod_nbit #(.n(4), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .bus(ifw));
  sync_updown_counter_mod_nbit #(.n(4), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .bus(ifs));
  sync_updown_counter_mod_nbit #(.n(4), .SATURATE(1'b0)) u_lo (
    .clk(clk), .reset(reset), .bus(iflo));
  sync_updown_counter_mod_nbit #(.n(4), .SATURATE(1'b0)) u_hi (
    .clk(clk), .reset(reset), .bus(ifhi));

  assign ifhi.en = iflo.tc;

  typedef struct {
    logic       clr;
    logic       ld;
    logic [3:0] d;
    logic       en;
    logic       up;
    logic [3:0] mx;
    logic       tc;
    logic [3:0] q;
    logic       ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input logic clr, input logic ld, input logic [3:0] d,
    input logic en, input logic up, input logic [3:0] mx,
    input logic tc, input logic [3:0] q, input logic ovf);
    vec_t v;
    v.clr = clr; v.ld = ld; v.d = d; v.en = en; v.up = up;
    v.mx = mx; v.tc = tc; v.q = q; v.ovf = ovf;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic clr, input logic ld,
                     input logic [3:0] d, input logic en,
                     input logic up, input logic [3:0] mx);
    ifw.clear = clr; ifw.load = ld; ifw.D = d;
    ifw.en = en; ifw.up_down = up; ifw.max_val = mx;
  endtask

  initial begin
    // test 2: modulus 9 up, then down from 3
    add(1,0,0, 0,1,9, 0, 0,0);
    for (int k = 0; k < 9; k++)
      add(0,0,0, 1,1,9, 0, 4'(k+1),0);
    add(0,0,0, 1,1,9, 1, 0,1);
    add(0,0,0, 1,1,9, 0, 1,1);
    add(0,0,0, 1,1,9, 0, 2,1);
    add(0,0,0, 1,1,9, 0, 3,1);
    add(0,0,0, 1,0,9, 0, 2,1);
    add(0,0,0, 1,0,9, 0, 1,1);
    add(0,0,0, 1,0,9, 0, 0,1);
    add(0,0,0, 1,0,9, 1, 9,1);
    // test 3: load above range, wrap, reload and count down
    add(1,0,0, 0,1,9, 0, 0,0);
    add(0,1,12, 1,1,9, 0, 12,0);
    add(0,0,0, 1,1,9, 1, 0,1);
    add(0,1,12, 1,0,9, 1, 12,1);
    add(0,0,0, 1,0,9, 0, 11,1);
    add(0,0,0, 1,0,9, 0, 10,1);
    add(0,0,0, 1,0,9, 0, 9,1);
    add(0,0,0, 1,0,9, 0, 8,1);
    // test 5: clear beats load and en, then hold
    add(1,1,7, 1,1,9, 0, 0,0);
    add(0,1,5, 0,1,9, 0, 5,0);
    for (int k = 0; k < 5; k++)
      add(0,0,0, 0,1,9, 0, 5,0);
    // max_val = 0
    add(0,0,0, 1,1,0, 1, 0,1);
    add(0,0,0, 1,0,0, 1, 0,1);
  end

  initial begin
    int cnt;
    reset = 1'b1;
    drv(0,0,0, 1,0,15);
    ifs.clear = 0; ifs.load = 0; ifs.D = 0;
    ifs.en = 0; ifs.up_down = 1; ifs.max_val = 6;
    iflo.clear = 0; iflo.load = 0; iflo.D = 0;
    iflo.en = 0; iflo.up_down = 1; iflo.max_val = 15;
    ifhi.clear = 0; ifhi.load = 0; ifhi.D = 0;
    ifhi.up_down = 1; ifhi.max_val = 15;
    @(posedge clk);
    #1;
    check("rst_q", ifw.Q, 0);
    check("rst_ovf", ifw.ovf, 0);
    check("rst_tc_down", ifw.tc, 1);

    // test 1: short wrap to set ovf, load 5, async reset
    @(negedge clk);
    reset = 1'b0;
    drv(0,0,0, 1,1,3);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("m4_q", ifw.Q, (k + 1) % 4);
      check("m4_ovf", ifw.ovf, (k >= 3) ? 1 : 0);
    end
    @(negedge clk);
    drv(0,1,5, 0,1,3);
    @(posedge clk);
    #1;
    check("ld5_q", ifw.Q, 5);
    @(negedge clk);
    drv(0,0,0, 0,1,3);
    #2 reset = 1'b1;
    #1;
    check("async_q", ifw.Q, 0);
    check("async_ovf", ifw.ovf, 0);
    @(negedge clk);
    reset = 1'b0;
    drv(0,0,0, 1,1,15);
    for (int k = 0; k < 16; k++) begin
      #1;
      check("up15_tc", ifw.tc, (k == 15) ? 1 : 0);
      @(posedge clk);
      #1;
      check("up15_q", ifw.Q, (k + 1) % 16);
      check("up15_ovf", ifw.ovf, (k == 15) ? 1 : 0);
      @(negedge clk);
    end

    // table-driven vectors
    foreach (vecs[i]) begin
      @(negedge clk);
      drv(vecs[i].clr, vecs[i].ld, vecs[i].d,
          vecs[i].en, vecs[i].up, vecs[i].mx);
      #1;
      check($sformatf("v%0d_tc", i), ifw.tc, vecs[i].tc);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_q", i), ifw.Q, vecs[i].q);
      check($sformatf("v%0d_ovf", i), ifw.ovf, vecs[i].ovf);
    end

    // test 4: saturate
    @(negedge clk);
    ifs.clear = 1;
    @(negedge clk);
    ifs.clear = 0; ifs.en = 1; ifs.up_down = 1; ifs.max_val = 6;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("sat_tc", ifs.tc, (k >= 6) ? 1 : 0);
      @(posedge clk);
      #1;
      check("sat_q", ifs.Q, (k < 6) ? k + 1 : 6);
      check("sat_ovf", ifs.ovf, (k >= 6) ? 1 : 0);
      @(negedge clk);
    end
    ifs.clear = 1;
    @(negedge clk);
    ifs.clear = 0; ifs.up_down = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("satdn_tc", ifs.tc, 1);
      @(posedge clk);
      #1;
      check("satdn_q", ifs.Q, 0);
      check("satdn_ovf", ifs.ovf, 1);
      @(negedge clk);
    end
    ifs.en = 0;

    // test 6: two-stage cascade
    iflo.en = 1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      cnt = (i + 1) % 256;
      check("casc", {ifhi.Q, iflo.Q}, cnt);
    end
    @(negedge clk);
    iflo.en = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
